// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column scan, press/release debounce,
// ghost-key rejection and a first-word-fall-through key-code queue.
module keypad_scan_fifo #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int SETTLE_CYCLES = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int KW = $clog2(ROWS*COLS),
  localparam int CW = $clog2(FIFO_DEPTH)+1
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic [ROWS-1:0] RowIn,
  output logic [COLS-1:0] ColOut,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [CW-1:0]   fifo_count,
  output logic            multi_key_err,
  output logic            overflow,
  input  logic            overflow_clr
);

  localparam int COLW = $clog2(COLS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SETTLE_CYCLES+1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES+1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    CAPTURE,
    RELEASE
  } state_e;

  state_e state_q, state_d;

  logic [ROWS-1:0] sync1_q, rs_q;
  logic [COLW-1:0] col_q, col_d, col_next;
  logic [SW-1:0]   settle_q, settle_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [ROWS-1:0] pat_q, pat_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;

  logic [FIFO_DEPTH-1:0][KW-1:0] mem_q, mem_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          rs_idle;
  logic          single;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr;
  logic [KW-1:0] cap_code;
  int            nlow;
  int            row_idx;
  int            code_full;

  // Two-flop row synchroniser; idle (pulled-up) level is all ones.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= '1;
      rs_q    <= '1;
    end else begin
      sync1_q <= RowIn;
      rs_q    <= sync1_q;
    end
  end

  assign rs_idle = &rs_q;
  assign col_next = (col_q == COLW'(COLS-1)) ? '0 : col_q + 1'b1;

  // Decode the latched pattern into a single row index and key code.
  always_comb begin
    nlow = 0;
    row_idx = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (!pat_q[r]) begin
        nlow = nlow + 1;
        row_idx = r;
      end
    end
    single = (nlow == 1);
    code_full = row_idx*COLS + int'(col_q);
    cap_code = code_full[KW-1:0];
  end

  // Scan/debounce/capture/release next-state logic.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    push     = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (settle_q == SW'(SETTLE_CYCLES)) begin
          if (!rs_idle) begin
            pat_d   = rs_q;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d    = col_next;
            settle_d = '0;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs_idle) begin
          state_d  = SCAN;
          settle_d = '0;
        end else if (rs_q == pat_q) begin
          if (cnt_q == DW'(DEBOUNCE_CYCLES-1)) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          pat_d = rs_q;
          cnt_d = '0;
        end
      end
      CAPTURE: begin
        push    = single;
        err_d   = !single;
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (rs_idle) begin
          if (cnt_q == DW'(DEBOUNCE_CYCLES-1)) begin
            state_d  = SCAN;
            col_d    = col_next;
            settle_d = '0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Queue bookkeeping: a pop frees the slot a same-cycle push needs.
  always_comb begin
    pop     = key_valid && key_ready;
    full    = (count_q == CW'(FIFO_DEPTH));
    wr      = push && (!full || pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (wr) begin
      mem_d[wptr_q] = cap_code;
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (wr && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr && pop) begin
      count_d = count_q - 1'b1;
    end
    if (push && !wr) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State, scan and queue registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= SCAN;
      col_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      pat_q    <= '1;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      mem_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  // One active-low column at a time.
  always_comb begin
    ColOut = '1;
    ColOut[col_q] = 1'b0;
  end

  assign key_valid     = (count_q != '0);
  assign key_code      = key_valid ? mem_q[rptr_q] : '0;
  assign fifo_count    = count_q;
  assign multi_key_err = err_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: keypad matrix model,
// table of single/ghost presses plus timed FIFO and reset sequences.
module tb_keypad_scan_fifo;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  RowIn;
  logic [3:0]  ColOut;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic [1:0]  fifo_count;
  logic        multi_key_err;
  logic        overflow;
  logic        overflow_clr;

  logic [15:0] keys;
  logic [3:0]  pops[$];
  int          err_cnt;
  int          valid_cyc;
  int          n_chk;
  int          n_fail;

  keypad_scan_fifo #(
    .ROWS(4),
    .COLS(4),
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES(3),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .RowIn(RowIn),
    .ColOut(ColOut),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .fifo_count(fifo_count),
    .multi_key_err(multi_key_err),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Keypad matrix: key r*4+c pulls row r low while column c is driven low.
  always_comb begin
    RowIn = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !ColOut[c]) RowIn[r] = 1'b0;
      end
    end
  end

  // Observe handshakes and error pulses mid-cycle.
  always @(negedge clk) begin
    if (nRST) begin
      if (key_valid && key_ready) pops.push_back(key_code);
      if (multi_key_err) err_cnt++;
      if (key_valid) valid_cyc++;
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          exp_pops;
    logic [3:0]  exp_code;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (pops.size() > i) return 32'(pops[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_mon();
    pops.delete();
    err_cnt = 0;
    valid_cyc = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [15:0] m, input int hold);
    keys = m;
    cyc(hold);
    keys = '0;
    cyc(30);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    cyc(1);
    key_ready = 1'b0;
  endtask

  task automatic wait_col(input logic [3:0] pat, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (ColOut == pat) found = 1'b1;
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: ColOut never reached %b", name, pat);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    keys = '0;
    key_ready = 1'b0;
    overflow_clr = 1'b0;
    clear_mon();

    vecs[0] = '{16'h0200, 1, 4'd9,  0};
    vecs[1] = '{16'h0001, 1, 4'd0,  0};
    vecs[2] = '{16'h8000, 1, 4'd15, 0};
    vecs[3] = '{16'h1010, 0, 4'd0,  1};
    vecs[4] = '{16'h0040, 1, 4'd6,  0};
    vecs[5] = '{16'h0404, 0, 4'd0,  1};

    nRST = 1'b0;
    cyc(3);
    chk("rst_colout", 32'(ColOut), 32'hE);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_err", 32'(multi_key_err), 0);
    chk("rst_ovf", 32'(overflow), 0);
    nRST = 1'b1;
    cyc(2);

    key_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      press(vecs[v].keys, 40);
      chk($sformatf("v%0d_pops", v), pops.size(), vecs[v].exp_pops);
      if (vecs[v].exp_pops > 0)
        chk($sformatf("v%0d_code", v), pop_at(0), 32'(vecs[v].exp_code));
      chk($sformatf("v%0d_err", v), err_cnt, vecs[v].exp_err);
      chk($sformatf("v%0d_vcyc", v), valid_cyc, vecs[v].exp_pops);
      chk($sformatf("v%0d_count", v), 32'(fifo_count), 0);
    end

    clear_mon();
    wait_col(4'b1011, "bounce_sync");
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      cyc(1);
    end
    press(16'h0008, 40);
    chk("bounce_pops", pops.size(), 1);
    chk("bounce_code", pop_at(0), 3);
    chk("bounce_err", err_cnt, 0);

    key_ready = 1'b0;
    clear_mon();
    press(16'h0020, 40);
    press(16'h0040, 40);
    press(16'h0400, 40);
    chk("ovf_count", 32'(fifo_count), 2);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_valid", 32'(key_valid), 1);
    chk("ovf_head", 32'(key_code), 5);
    pop_one();
    chk("ovf_head2", 32'(key_code), 6);
    chk("ovf_count1", 32'(fifo_count), 1);
    pop_one();
    chk("ovf_count0", 32'(fifo_count), 0);
    chk("ovf_valid0", 32'(key_valid), 0);
    chk("ovf_pop0", pop_at(0), 5);
    chk("ovf_pop1", pop_at(1), 6);
    chk("ovf_sticky", 32'(overflow), 1);
    overflow_clr = 1'b1;
    cyc(1);
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    clear_mon();
    press(16'h0001, 40);
    press(16'h0002, 40);
    chk("pp_full", 32'(fifo_count), 2);
    wait_col(4'b1011, "pp_pre");
    keys = 16'h8000;
    wait_col(4'b0111, "pp_entry");
    cyc(8);
    pop_one();
    chk("pp_count", 32'(fifo_count), 2);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_pop", pop_at(0), 0);
    chk("pp_head", 32'(key_code), 1);
    keys = '0;
    cyc(30);
    pop_one();
    chk("pp_tail", 32'(key_code), 15);

    wait_col(4'b1101, "rst_pre");
    keys = 16'h0400;
    wait_col(4'b1011, "rst_entry");
    cyc(5);
    chk("mid_valid_pre", 32'(key_valid), 1);
    nRST = 1'b0;
    #1;
    chk("mid_colout", 32'(ColOut), 32'hE);
    chk("mid_valid", 32'(key_valid), 0);
    chk("mid_count", 32'(fifo_count), 0);
    cyc(3);
    nRST = 1'b1;
    clear_mon();
    key_ready = 1'b1;
    cyc(60);
    keys = '0;
    cyc(30);
    chk("post_pops", pops.size(), 1);
    chk("post_code", pop_at(0), 10);
    chk("post_err", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
